mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares the single external memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage, fed by the EX/MEM register's aluop/mem_addr/reg2 decode).
Runs one bus transaction at a time and gives the MEM port priority.
Raises per-port stall requests to the pipeline controller until that port's access is served.
Holds each result until the owning stage advances, so a stalled stage never re-issues an access. This matters most for writes.

Parameters:
ADDR_W, 32, byte-address width of both ports and the bus
DATA_W, 32, data width; the byte-select width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  6  pipeline stall vector (bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb); 1 = Stop
flush  in  1  pipeline flush (exception/branch redirect)
if_ce  in  1  IF read request (level)
if_addr  in  ADDR_W  IF fetch address
if_rdata  out  DATA_W  fetched word, registered
stallreq_if  out  1  IF stall request
mem_ce  in  1  MEM request (level)
mem_we  in  1  1 = write
mem_addr  in  ADDR_W  data address
mem_sel  in  DATA_W/8  byte enables
mem_wdata  in  DATA_W  write data
mem_rdata  out  DATA_W  read data, registered
stallreq_mem  out  1  MEM stall request
bus_stb  out  1  transaction active
bus_we  out  1  bus write
bus_addr  out  ADDR_W  bus address
bus_sel  out  DATA_W/8  bus byte enables
bus_wdata  out  DATA_W  bus write data
bus_ack  in  1  slave completion, one cycle, any latency ≥1 after stb rises
bus_rdata  in  DATA_W  read data, valid with bus_ack

Behaviour:
- States: IDLE, IF_ACC, MEM_ACC.
- Internal flags: if_served, mem_served, if_discard.
- Reset: state IDLE; all flags 0; all bus_* outputs 0; if_rdata 0; mem_rdata 0. Reset mid-transaction drops bus_stb on the next edge. Slaves tolerate an abandoned access.
- Stall requests are combinational:
  - stallreq_if = if_ce & ~if_served, and also 1 whenever state==IF_ACC.
  - stallreq_mem = mem_ce & ~mem_served.
- IDLE transitions:
  - If mem_ce & ~mem_served: go to MEM_ACC and latch mem_we/addr/sel/wdata onto the bus regs; bus_stb=1.
  - Else if if_ce & ~if_served & ~flush: go to IF_ACC with bus_we=0, bus_sel=all ones, bus_addr=if_addr.
- MEM priority is unconditional. Bus outputs stay stable for the whole ACC state.
- ACC state on bus_ack: bus_stb<=0, state<=IDLE.
  - MEM_ACC: mem_served<=1; mem_rdata<=bus_rdata on reads, unchanged on writes.
  - IF_ACC: if if_discard, clear it and leave if_rdata unchanged; else if_served<=1 and if_rdata<=bus_rdata.
- Every transaction is followed by one IDLE cycle, so the minimum access takes 3 cycles from request to stallreq drop.
- Served release:
  - if_served clears on an edge with stall[1]==0 or flush.
  - mem_served clears on an edge with stall[4]==0.
  - If a set and a clear coincide, the set wins.
- Flush handling:
  - Flush during IF_ACC sets if_discard; the access runs to ack and its result is dropped.
  - Flush never aborts MEM_ACC: the MEM-stage instruction is committed.
  - Flush in IDLE blocks a new IF grant that cycle.
- if_ce/mem_ce deasserting mid-ACC does not abort the access. The result is recorded, and the served flag clears with the stage advance.
- No bus timeout; a missing ack stalls forever (documented).

Decomposition:
- Shared defines (defines.v): Stop/NoStop, RstEnable, ZeroWord, and the state encodings ARB_IDLE/ARB_IF/ARB_MEM.
- Single module; no sub-module is warranted.

Test Plan:
1. IF read only, if_addr=0x100, ack 2 cycles after stb, bus_rdata=0x24020005 -> bus_addr=0x100, bus_we=0; if_rdata=0x24020005; stallreq_if drops on the cycle after ack; a single stb pulse.
2. if_ce and mem_ce (write 0xDEADBEEF to 0x2000, sel=0xF) raised together -> MEM write on the bus first, then IF read; stallreq_if stays high throughout.
3. MEM write served while stall[4]=1 held for 5 cycles -> exactly one bus write; stallreq_mem=0 while held; a new access is issued only after stall[4]=0 and mem_ce is still set.
4. Flush asserted during IF_ACC at 0x300 -> access completes on ack; if_rdata unchanged and if_served=0; the next fetch of redirected address 0x400 issues a new transaction.
5. rst asserted mid-MEM_ACC -> next edge: bus_stb=0, state IDLE, stallreq_* follow ce only; no served flag set.
6. Byte read, mem_sel=0x2, ack after 1 cycle with bus_rdata=0x0000AB00 -> bus_sel=0x2; mem_rdata=0x0000AB00; mem_rdata holds until the next MEM read.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter:
//   - arb_state_t : arbiter state encoding (idle, IF access, MEM access)
//   - STOP/NO_STOP : meaning of a bit in the pipeline stall vector
//   - RST_ENABLE : active level of the synchronous reset
//   - STALL_IF_BIT/STALL_MEM_BIT : positions of the IF and MEM stages in stall
//   - stage_advances() : true when the given stage moves on this edge
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2
  } arb_state_t;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  localparam int STALL_IF_BIT  = 1;
  localparam int STALL_MEM_BIT = 4;

  function automatic logic stage_advances(input logic [5:0] stall_vec, input int bit_idx);
    return stall_vec[bit_idx] == NO_STOP;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external memory bus between the instruction-fetch (IF) port and
// the data (MEM) port. One bus transaction runs at a time, MEM always wins,
// and each port's result is held (with a "served" flag) until its pipeline
// stage advances, so a stalled stage never re-issues an access.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        pipeline stall vector (1 = stop); bit1 IF, bit4 MEM
//   flush             pipeline redirect; drops an in-flight fetch result
//   if_ce/if_addr     IF read request (level) and fetch address
//   if_rdata          fetched word (registered)
//   stallreq_if       IF stall request (combinational)
//   mem_ce/mem_we/mem_addr/mem_sel/mem_wdata  MEM request (level)
//   mem_rdata         MEM read data (registered)
//   stallreq_mem      MEM stall request (combinational)
//   bus_stb/bus_we/bus_addr/bus_sel/bus_wdata  bus master outputs (registered)
//   bus_ack/bus_rdata bus slave completion and read data
//
// There is no bus timeout: a slave that never acks stalls the pipeline forever.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                if_ce,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                stallreq_if,
  input  logic                mem_ce,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_mem,
  output logic                bus_stb,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_t        state_reg;
  logic              if_served_reg;
  logic              mem_served_reg;
  logic              if_discard_reg;
  logic              bus_stb_reg;
  logic              bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [SEL_W-1:0]  bus_sel_reg;
  logic [DATA_W-1:0] bus_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] mem_rdata_reg;

  // IF keeps requesting a stall for the whole fetch, even if the stage
  // dropped if_ce meanwhile, so the pipeline cannot move past a live fetch.
  assign stallreq_if  = (if_ce & ~if_served_reg) | (state_reg == ARB_IF);
  assign stallreq_mem = mem_ce & ~mem_served_reg;

  assign bus_stb   = bus_stb_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_sel   = bus_sel_reg;
  assign bus_wdata = bus_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg      <= ARB_IDLE;
      if_served_reg  <= 1'b0;
      mem_served_reg <= 1'b0;
      if_discard_reg <= 1'b0;
      bus_stb_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= '0;
      bus_sel_reg    <= '0;
      bus_wdata_reg  <= '0;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
    end else begin
      // Served flags release when their stage advances. The set below is
      // written later in the block so that it wins on a coinciding edge.
      if (stage_advances(stall, STALL_IF_BIT) || flush) begin
        if_served_reg <= 1'b0;
      end
      if (stage_advances(stall, STALL_MEM_BIT)) begin
        mem_served_reg <= 1'b0;
      end

      case (state_reg)
        ARB_IDLE: begin
          if (mem_ce && !mem_served_reg) begin
            state_reg     <= ARB_MEM;
            bus_stb_reg   <= 1'b1;
            bus_we_reg    <= mem_we;
            bus_addr_reg  <= mem_addr;
            bus_sel_reg   <= mem_sel;
            bus_wdata_reg <= mem_wdata;
          end else if (if_ce && !if_served_reg && !flush) begin
            state_reg    <= ARB_IF;
            bus_stb_reg  <= 1'b1;
            bus_we_reg   <= 1'b0;
            bus_addr_reg <= if_addr;
            bus_sel_reg  <= '1;
          end
        end

        ARB_IF: begin
          if (bus_ack) begin
            state_reg   <= ARB_IDLE;
            bus_stb_reg <= 1'b0;
            // A flush landing on the ack edge also makes the word stale.
            if (if_discard_reg || flush) begin
              if_discard_reg <= 1'b0;
            end else begin
              if_served_reg <= 1'b1;
              if_rdata_reg  <= bus_rdata;
            end
          end else if (flush) begin
            // The bus cycle cannot be withdrawn; let it finish, drop the data.
            if_discard_reg <= 1'b1;
          end
        end

        ARB_MEM: begin
          // Flush is ignored here: the MEM-stage instruction is committed.
          if (bus_ack) begin
            state_reg      <= ARB_IDLE;
            bus_stb_reg    <= 1'b0;
            mem_served_reg <= 1'b1;
            if (!bus_we_reg) begin
              mem_rdata_reg <= bus_rdata;
            end
          end
        end

        default: begin
          state_reg   <= ARB_IDLE;
          bus_stb_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
